bus_hub_n: RTL
==============

BUS_HUB_N -- requirements
Module: bus_hub_n

Interface
REQ-001 SHALL have parameter N_DEVICES, default 5, number of device ports (1..16).
REQ-002 SHALL have parameter DEV_BASE, default 0, packed N_DEVICES x 32-bit base addresses; slot i is bits [32*i+31:32*i].
REQ-003 SHALL have parameter DEV_MASK, default 0, packed N_DEVICES x 32-bit masks; a set bit means that address bit is decoded.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum number of cycles to wait for device_ready (1..65535).
REQ-005 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, read data returned on an error.
REQ-006 Ports, as name  direction  width  meaning:
  - clk  in  1  single clock; all logic on its rising edge
  - rst_n  in  1  asynchronous, active-low reset
  - host_address  in  32  request address
  - host_data_write  in  32  write data
  - host_write_mask  in  4  byte enables
  - host_ren  in  1  read request, held until host_ready
  - host_wen  in  1  write request, held until host_ready
  - host_data_read  out  32  read data, valid while host_ready is high
  - host_ready  out  1  one-cycle completion pulse
  - device_address  out  N*32  address offset (host_address & ~DEV_MASK)
  - device_data_write  out  N*32  latched write data
  - device_write_mask  out  N*4  latched byte enables
  - device_ren  out  N  one-cycle read strobe
  - device_wen  out  N  one-cycle write strobe
  - device_active  out  N  one-hot select for the whole transaction
  - device_ready  in  N  device completion
  - device_data_read  in  N*32  device read data
  - bus_error  out  1  sticky error flag
  - error_address  out  32  address of the first unacknowledged error
  - error_clear  in  1  clears bus_error

Function
REQ-007 SHALL decode a hit for slot i when (host_address & mask_i) == (base_i & mask_i); if several slots hit, the lowest index SHALL win.
REQ-008 SHALL use FSM states IDLE, STROBE, WAIT, RESP, ERR.
REQ-009 IDLE: when host_ren or host_wen is high, the block SHALL latch the address, data, mask, operation and decoded index.
  - Hit: go to STROBE.
  - No hit, or host_ren and host_wen both high: go to ERR.
REQ-010 STROBE: the block SHALL hold device_active[idx] high and pulse device_ren[idx] or device_wen[idx] for exactly one cycle, then go to WAIT; a device_ready already high in this cycle SHALL be honoured.
REQ-011 WAIT: on device_ready[idx] the block SHALL capture device_data_read slot idx and go to RESP; device_ready on any non-selected slot SHALL be ignored.
REQ-012 The timeout counter SHALL be 16 bits, clear on entry to STROBE and increment in WAIT; when it reaches TIMEOUT_CYCLES with no device_ready, the block SHALL go to ERR.
REQ-013 RESP: the block SHALL pulse host_ready for one cycle, drive the captured data (reads) or 0 (writes), deassert device_active, and return to IDLE.
REQ-014 ERR: the block SHALL pulse host_ready for one cycle with host_data_read = ERR_DATA and set bus_error; error_address SHALL be loaded only if bus_error was clear. Return to IDLE.
REQ-015 Latency, request to host_ready: hit with a same-cycle ready = 2 cycles (STROBE, RESP); decode error = 1 cycle (ERR).
REQ-016 A request still asserted in the cycle after host_ready SHALL be treated as a new transaction.
REQ-017 Outputs to non-selected slots SHALL be 0; device_address, device_data_write and device_write_mask SHALL be stable from STROBE through RESP.
REQ-018 error_clear SHALL clear bus_error in IDLE; if it coincides with ERR, the set SHALL win.

Reset
REQ-019 Asserting rst_n low SHALL immediately force state IDLE and clear the counter, host_ready, host_data_read, all device_* outputs, bus_error and error_address.
REQ-020 A transaction in flight at reset SHALL be abandoned with no host_ready.
REQ-021 Deassertion of rst_n SHALL be synchronised internally with a 2-flop synchroniser.

Structure
REQ-022 The FSM state enum and the ERR_DATA default SHALL live in shared package bus_pkg.
REQ-023 The address match and priority encode SHALL be a combinational sub-module, bus_addr_decoder (outputs hit and idx).

Verification
REQ-024 Read hit: N=2, slot1 base 32'h0001_0000, mask 32'hFFFF_0000; read 32'h0001_0024 with the device returning 32'hCAFE_0001 in STROBE.
  - device_address slot1 = 32'h24.
  - host_ready 2 cycles after the request, data 32'hCAFE_0001.
REQ-025 Write: write 32'h1234_5678, mask 4'b0011 to slot 0.
  - device_wen[0] high for exactly 1 cycle, with the latched data and mask.
  - device_ren stays 0.
REQ-026 Decode miss: read 32'hF000_0000.
  - host_ready after 1 cycle, data 32'hDEADBEEF.
  - bus_error = 1, error_address = 32'hF000_0000.
REQ-027 Timeout: TIMEOUT_CYCLES=8, device never ready.
  - host_ready 10 cycles after the request, with ERR_DATA.
  - A second error leaves error_address unchanged.
REQ-028 Overlap and late ready: slots 0 and 1 both match; a stray device_ready[1] arrives during WAIT.
  - Slot 0 is selected.
  - The stray ready is ignored; completion follows device_ready[0].
REQ-029 Reset mid-WAIT: drive rst_n low.
  - All outputs are 0 in the same cycle.
  - No host_ready pulse.
  - The next request completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus hub.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP,
    ERR
  } bus_state_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;
  localparam int unsigned IDX_W        = 4;

endpackage

// File: rtl/bus_addr_decoder.sv
// Base/mask address match with lowest-index priority.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int unsigned               N_DEVICES = 5,
  parameter logic [32*N_DEVICES-1:0]   DEV_BASE  = '0,
  parameter logic [32*N_DEVICES-1:0]   DEV_MASK  = '0
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < N_DEVICES; i++) begin
      if (!hit && ((addr & DEV_MASK[32*i +: 32]) ==
                   (DEV_BASE[32*i +: 32] & DEV_MASK[32*i +: 32]))) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_hub_n.sv
// Single-master hub: decodes a host request to one of N device ports,
// waits for completion with a timeout, and reports sticky bus errors.
module bus_hub_n
  import bus_pkg::*;
#(
  parameter int unsigned             N_DEVICES      = 5,
  parameter logic [32*N_DEVICES-1:0] DEV_BASE       = '0,
  parameter logic [32*N_DEVICES-1:0] DEV_MASK       = '0,
  parameter int unsigned             TIMEOUT_CYCLES = 255,
  parameter logic [31:0]             ERR_DATA       = BUS_ERR_DATA
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               host_address,
  input  logic [31:0]               host_data_write,
  input  logic [3:0]                host_write_mask,
  input  logic                      host_ren,
  input  logic                      host_wen,
  output logic [31:0]               host_data_read,
  output logic                      host_ready,
  output logic [32*N_DEVICES-1:0]   device_address,
  output logic [32*N_DEVICES-1:0]   device_data_write,
  output logic [4*N_DEVICES-1:0]    device_write_mask,
  output logic [N_DEVICES-1:0]      device_ren,
  output logic [N_DEVICES-1:0]      device_wen,
  output logic [N_DEVICES-1:0]      device_active,
  input  logic [N_DEVICES-1:0]      device_ready,
  input  logic [32*N_DEVICES-1:0]   device_data_read,
  output logic                      bus_error,
  output logic [31:0]               error_address,
  input  logic                      error_clear
);

  logic [1:0]       rst_sync;
  logic             rst_i_n;
  bus_state_e       state_q, state_d;
  logic [31:0]      addr_q, wdata_q, rdata_q, err_addr_q;
  logic [3:0]       wmask_q;
  logic [IDX_W-1:0] idx_q, dec_idx;
  logic             is_read_q, bus_error_q, dec_hit;
  logic [15:0]      cnt_q;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic             req;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  bus_addr_decoder #(
    .N_DEVICES (N_DEVICES),
    .DEV_BASE  (DEV_BASE),
    .DEV_MASK  (DEV_MASK)
  ) u_dec (
    .addr (host_address),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign req = host_ren | host_wen;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_DEVICES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = device_ready[i];
        sel_rdata = device_data_read[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (req) state_d = (!dec_hit || (host_ren && host_wen)) ? ERR : STROBE;
      STROBE: state_d = sel_ready ? RESP : WAIT;
      WAIT: begin
        if (sel_ready)                                  state_d = RESP;
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1))      state_d = ERR;
      end
      RESP:   state_d = IDLE;
      ERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      idx_q       <= '0;
      is_read_q   <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (error_clear) bus_error_q <= 1'b0;
          if (req) begin
            addr_q    <= host_address;
            wdata_q   <= host_data_write;
            wmask_q   <= host_write_mask;
            idx_q     <= dec_idx;
            is_read_q <= host_ren;
            rdata_q   <= '0;
            cnt_q     <= '0;
          end
        end
        STROBE, WAIT: begin
          if (sel_ready && is_read_q) rdata_q <= sel_rdata;
          if (state_q == WAIT)        cnt_q   <= cnt_q + 16'd1;
        end
        ERR: begin
          bus_error_q <= 1'b1;
          if (!bus_error_q) err_addr_q <= addr_q;
        end
        default: ;
      endcase
    end
  end

  // Device-side outputs are pure decodes of state and latched request,
  // so reset zeroes them in the same cycle.
  always_comb begin
    host_ready        = (state_q == RESP) || (state_q == ERR);
    host_data_read    = '0;
    device_address    = '0;
    device_data_write = '0;
    device_write_mask = '0;
    device_ren        = '0;
    device_wen        = '0;
    device_active     = '0;
    if (state_q == RESP)     host_data_read = rdata_q;
    else if (state_q == ERR) host_data_read = ERR_DATA;
    for (int unsigned i = 0; i < N_DEVICES; i++) begin
      if ((idx_q == IDX_W'(i)) &&
          ((state_q == STROBE) || (state_q == WAIT) || (state_q == RESP))) begin
        device_address[32*i +: 32]   = addr_q & ~DEV_MASK[32*i +: 32];
        device_data_write[32*i +: 32] = wdata_q;
        device_write_mask[4*i +: 4]  = wmask_q;
        device_active[i]             = (state_q != RESP);
        device_ren[i]                = (state_q == STROBE) && is_read_q;
        device_wen[i]                = (state_q == STROBE) && !is_read_q;
      end
    end
  end

  assign bus_error     = bus_error_q;
  assign error_address = err_addr_q;

endmodule
